// File: rtl/reg_file.sv
// Register file with two combinational read ports and one synchronous write port; x0 is hardwired to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_WRITE_BYPASS_EN.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWrite,
  input  logic [4:0]      Rs1,
  input  logic [4:0]      Rs2,
  input  logic [4:0]      Rd,
  input  logic [XLEN-1:0] Write_data,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  // Reset dominates; x0 and indices beyond NREGS are never written.
  assign wr_en = RegWrite && !reset && (Rd != 5'd0) && (32'(Rd) < NREGS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[Rd] <= Write_data;
    end
  end

  always_comb begin
    read_data1 = '0;
    if ((Rs1 != 5'd0) && (32'(Rs1) < NREGS)) begin
      read_data1 = regs[Rs1];
    end
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (wr_en && (Rs1 == Rd)) begin
      read_data1 = Write_data;
    end
`endif
  end

  always_comb begin
    read_data2 = '0;
    if ((Rs2 != 5'd0) && (32'(Rs2) < NREGS)) begin
      read_data2 = regs[Rs2];
    end
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (wr_en && (Rs2 == Rd)) begin
      read_data2 = Write_data;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand sequences for the
// forwarding/reset corner cases, then randomized traffic against an array model.
module tb_reg_file;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            RegWrite;
  logic [4:0]      Rs1;
  logic [4:0]      Rs2;
  logic [4:0]      Rd;
  logic [XLEN-1:0] Write_data;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] model_regs [32];
  logic [XLEN-1:0] exp_q [$];

  typedef struct {
    logic            rst;
    logic            we;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic            chk;
    logic [XLEN-1:0] exp1;
    logic [XLEN-1:0] exp2;
  } vec_t;

  vec_t vecs [14];

  reg_file #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .Rs1        (Rs1),
    .Rs2        (Rs2),
    .Rd         (Rd),
    .Write_data (Write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset      = 1'b1;
    RegWrite   = 1'b0;
    Rs1        = '0;
    Rs2        = '0;
    Rd         = '0;
    Write_data = '0;
  end

  function automatic vec_t mk(logic rst, logic we, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [XLEN-1:0] wdata, logic chk,
                              logic [XLEN-1:0] exp1, logic [XLEN-1:0] exp2);
    vec_t v;
    v.rst = rst; v.we = we; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.wdata = wdata; v.chk = chk; v.exp1 = exp1; v.exp2 = exp2;
    return v;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // driver: present inputs after the falling edge; they commit on the next rising edge
  task automatic drive(input logic rst, input logic we, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [XLEN-1:0] wdata);
    @(negedge clk);
    reset      = rst;
    RegWrite   = we;
    Rs1        = rs1;
    Rs2        = rs2;
    Rd         = rd;
    Write_data = wdata;
    #1;
  endtask

  // reference model: what the architectural state says each read port shows before the edge
  function automatic logic [XLEN-1:0] model_read(logic [4:0] rs, logic rst, logic we,
                                                 logic [4:0] rd, logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] v;
    v = (rs == 5'd0) ? '0 : model_regs[rs];
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (we && !rst && rd != 5'd0 && rd == rs) v = wdata;
`endif
    return v;
  endfunction

  function automatic void model_edge(logic rst, logic we, logic [4:0] rd, logic [XLEN-1:0] wdata);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
    end else if (we && rd != 5'd0) begin
      model_regs[rd] = wdata;
    end
  endfunction

  initial begin
    logic            r_rst, r_we;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [XLEN-1:0] r_wd;

    vecs[0]  = mk(1, 0, 0, 1, 0, 32'h0,        0, 32'h0,        32'h0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h0,        32'h0);
    vecs[2]  = mk(0, 1, 0, 0, 1, 32'hA5A5A5A5, 1, 32'h0,        32'h0);
    vecs[3]  = mk(0, 1, 1, 0, 2, 32'h5A5A5A5A, 1, 32'hA5A5A5A5, 32'h0);
    vecs[4]  = mk(0, 1, 1, 2, 3, 32'hDEADBEEF, 1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    vecs[5]  = mk(0, 0, 3, 0, 0, 32'h0,        1, 32'hDEADBEEF, 32'h0);
    vecs[6]  = mk(0, 1, 0, 1, 0, 32'hFFFFFFFF, 1, 32'h0,        32'hA5A5A5A5);
    vecs[7]  = mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h0,        32'hA5A5A5A5);
    vecs[8]  = mk(0, 0, 2, 2, 2, 32'h12345678, 1, 32'h5A5A5A5A, 32'h5A5A5A5A);
    vecs[9]  = mk(0, 0, 2, 3, 0, 32'h0,        1, 32'h5A5A5A5A, 32'hDEADBEEF);
    vecs[10] = mk(0, 1, 1, 2, 3, 32'hCAFEBABE, 1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    vecs[11] = mk(0, 0, 3, 3, 0, 32'h0,        1, 32'hCAFEBABE, 32'hCAFEBABE);
    vecs[12] = mk(1, 1, 3, 1, 3, 32'h11111111, 1, 32'hCAFEBABE, 32'hA5A5A5A5);
    vecs[13] = mk(0, 0, 3, 1, 0, 32'h0,        1, 32'h0,        32'h0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wdata);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].exp1);
        check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].exp2);
      end
    end

    // same-cycle write/read of x5, then read back after the edge
    drive(0, 1, 5, 5, 5, 32'h0BADF00D);
`ifdef REG_FILE_WRITE_BYPASS_EN
    check("fwd_pre_rd1", read_data1, 32'h0BADF00D);
    check("fwd_pre_rd2", read_data2, 32'h0BADF00D);
`else
    check("fwd_pre_rd1", read_data1, 32'h0);
    check("fwd_pre_rd2", read_data2, 32'h0);
`endif
    drive(0, 0, 5, 0, 0, 32'h0);
    check("fwd_post_rd1", read_data1, 32'h0BADF00D);
    check("fwd_post_rd2", read_data2, 32'h0);

    // x0 target never forwards, in either build
    drive(0, 1, 0, 0, 0, 32'h87654321);
    check("x0_fwd_rd1", read_data1, 32'h0);
    check("x0_fwd_rd2", read_data2, 32'h0);

    // x31 boundary, and a reset that discards a concurrent write
    drive(0, 1, 0, 0, 31, 32'h80000001);
    drive(1, 1, 31, 5, 31, 32'h7FFFFFFE);
    check("rst_pre_rd1", read_data1, 32'h80000001);
    check("rst_pre_rd2", read_data2, 32'h0BADF00D);
    drive(0, 0, 31, 5, 0, 32'h0);
    check("rst_post_rd1", read_data1, 32'h0);
    check("rst_post_rd2", read_data2, 32'h0);

    for (int i = 0; i < 32; i++) model_regs[i] = '0;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 31) == 0);
      r_we  = ($urandom_range(0, 3) != 0);
      r_rd  = 5'($urandom_range(0, 31));
      r_rs1 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_rs2 = ($urandom_range(0, 3) == 0) ? r_rs1 : 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      exp_q.push_back(model_read(r_rs1, r_rst, r_we, r_rd, r_wd));
      exp_q.push_back(model_read(r_rs2, r_rst, r_we, r_rd, r_wd));
      drive(r_rst, r_we, r_rs1, r_rs2, r_rd, r_wd);
      check("rand_rd1", read_data1, exp_q.pop_front());
      check("rand_rd2", read_data2, exp_q.pop_front());
      model_edge(r_rst, r_we, r_rd, r_wd);
    end

    // final sweep of every register through both ports
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 5'(i), 5'(31 - i), 0, 32'h0);
      check("sweep_rd1", read_data1, (i == 0) ? 32'h0 : model_regs[i]);
      check("sweep_rd2", read_data2, (i == 31) ? 32'h0 : model_regs[31 - i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
